// File: rtl/multi_channel_accumulator.sv
// Per-channel running-sum accumulator with a valid/ready sample input and a single
// registered valid/ready result stage; wrap or saturate arithmetic selected by SAT_MODE.
module multi_channel_accumulator #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SAT_MODE = 0,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAN_W-1:0] in_chan,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_clear,
  input  logic              clr_all,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAN_W-1:0] out_chan,
  output logic [WIDTH-1:0]  out_sum,
  output logic              out_ovf
);

  logic [WIDTH-1:0]  acc_q [CHANNELS];
  logic [WIDTH-1:0]  acc_d [CHANNELS];
  logic              out_valid_q, out_valid_d;
  logic [CHAN_W-1:0] out_chan_q, out_chan_d;
  logic [WIDTH-1:0]  out_sum_q, out_sum_d;
  logic              out_ovf_q, out_ovf_d;

  logic              accept_s;
  logic              chan_ok_s;
  logic [31:0]       chan_ext_s;
  logic [WIDTH-1:0]  base_s;
  logic [WIDTH:0]    sum_s;
  logic              ovf_s;
  logic [WIDTH-1:0]  new_s;

  assign in_ready   = !out_valid_q | out_ready;
  assign accept_s   = in_valid & in_ready;
  assign chan_ext_s = {{(32-CHAN_W){1'b0}}, in_chan};
  // Indices past CHANNELS are swallowed: accepted but never touch state or output.
  assign chan_ok_s  = (chan_ext_s < 32'(CHANNELS));

  // Datapath: select base, add with carry, apply wrap or clamp.
  always_comb begin
    base_s = {WIDTH{1'b0}};
    if (clr_all || in_clear || !chan_ok_s) begin
      base_s = {WIDTH{1'b0}};
    end else begin
      base_s = acc_q[in_chan];
    end
    sum_s = {1'b0, base_s} + {1'b0, in_data};
    ovf_s = sum_s[WIDTH];
    if ((SAT_MODE != 0) && ovf_s) begin
      new_s = {WIDTH{1'b1}};
    end else begin
      new_s = sum_s[WIDTH-1:0];
    end
  end

  // Next-state for accumulators and the result register.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      acc_d[i] = clr_all ? {WIDTH{1'b0}} : acc_q[i];
    end
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    if (accept_s && chan_ok_s) begin
      acc_d[in_chan] = new_s;
      out_valid_d    = 1'b1;
      out_chan_d     = in_chan;
      out_sum_d      = new_s;
      out_ovf_d      = ovf_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= {WIDTH{1'b0}};
      end
      out_valid_q <= 1'b0;
      out_chan_q  <= {CHAN_W{1'b0}};
      out_sum_q   <= {WIDTH{1'b0}};
      out_ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= acc_d[i];
      end
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/multi_channel_accumulator.md
Name: multi_channel_accumulator

Overview:
- Parametrised successor to the single-input clocked adder.
- Keeps one running sum per channel and accepts one sample per cycle on a valid/ready input.
- Emits the updated sum through a registered valid/ready output.
- Supports wrap or saturate arithmetic, per-sample clear and a global clear.
- Sits between sample producers and downstream statistics logic in the simulator datapath.

Parameters:
- WIDTH, 16, bit width of samples and accumulators (unsigned), minimum 2.
- CHANNELS, 4, number of independent accumulators, range 1..16.
- SAT_MODE, 0, 0 = modulo 2^WIDTH wrap; 1 = clamp to 2^WIDTH-1.
- CHAN_W, max(1,clog2(CHANNELS)), width of the channel index (derived, not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample this cycle.
- in_chan  input  CHAN_W  target channel.
- in_data  input  WIDTH  sample value.
- in_clear  input  1  replace the channel sum with in_data instead of adding.
- clr_all  input  1  synchronous clear of every accumulator.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_chan  output  CHAN_W  channel of the result.
- out_sum  output  WIDTH  updated channel sum.
- out_ovf  output  1  this update overflowed (carry out of the WIDTH-bit add).

Behaviour:
- Reset is asynchronous, active-low, on rst; the clock is clk. While rst=0:
  - all accumulators are 0;
  - out_valid=0, out_sum=0, out_chan=0, out_ovf=0.
  - Reset mid-operation drops any pending result and all sums.
- Accept condition: in_valid & in_ready.
- in_ready = !out_valid | out_ready (combinational; a single output register).
- Update, on accept with c = in_chan:
  - base = (clr_all | in_clear) ? 0 : acc[c].
  - Form the WIDTH+1-bit sum s = base + in_data.
  - ovf = s[WIDTH].
  - Wrap mode: new = s[WIDTH-1:0].
  - Saturate mode: new = ovf ? all-ones : s[WIDTH-1:0].
  - acc[c] <= new.
- Output after accept:
  - out_sum <= new, out_chan <= c, out_ovf <= ovf, out_valid <= 1 on the same edge.
  - Latency is 1 cycle from accept edge to out_valid high.
- Output hold: while out_valid=1 and out_ready=0, out_sum, out_chan and out_ovf are stable and in_ready=0.
- Output drain: on out_ready=1 with no new accept, out_valid <= 0. out_sum, out_chan and out_ovf keep their last values.
- Simultaneous drain and accept: new result loaded, out_valid stays 1. This gives full throughput of 1 sample/cycle.
- clr_all:
  - Every accumulator becomes 0 at the edge, regardless of in_valid.
  - If a sample is accepted in the same cycle, its channel ends at new (computed from base 0); all other channels end at 0.
  - clr_all does not affect the output register.
- Out-of-range channel (in_chan >= CHANNELS, only possible when CHANNELS is not a power of 2):
  - the sample is accepted;
  - no accumulator changes;
  - no result is produced (out_valid unchanged by it, except draining normally).
- Saturate mode: once a channel clamps it stays at all-ones until cleared. Each further nonzero add reports ovf=1; adding 0 reports ovf=0.
- Accumulator storage is a register array; no RAM inference is required.

Test Plan:
- WIDTH=8, CHANNELS=4, SAT_MODE=0, out_ready=1:
  - stimulus: ch1 gets 100, 100, 100.
  - response: out_sum 100, 200, 44; out_ovf 0, 0, 1.
  - response: out_chan=1 each cycle, back-to-back with out_valid continuously 1.
- SAT_MODE=1, same stimulus -> out_sum 100, 200, 255 with out_ovf 0, 0, 1; a further add of 0 -> 255 with out_ovf=0.
- Backpressure (out_ready=0 for 3 cycles after the first result, in_valid held with ch2=5, then ch2=7):
  - in_ready=0 while out_valid=1;
  - out_sum stays 5 for 3 cycles;
  - after release, the next result is 12.
- Channel isolation and in_clear:
  - stimulus: ch0 +10, ch3 +20, ch0 +5 with in_clear=1, ch3 +1.
  - response: results are (0,10), (3,20), (0,5), (3,21).
- clr_all:
  - setup: ch0=50, ch2=30.
  - stimulus: clr_all=1 in the same cycle as a ch2 +4 accept.
  - response: out_sum=4.
  - follow-up: ch0 +1 -> 1.
- Async reset:
  - stimulus: assert rst=0 mid-cycle while out_valid=1 and out_ready=0.
  - response: out_valid, out_sum, out_ovf drop to 0 immediately.
  - follow-up: after release, ch1 +3 -> out_sum=3.
